osnt_sume_tx_pkt_arbiter: RTL and testbench
===========================================

# osnt_sume_tx_pkt_arbiter

Packet-granular round-robin arbiter sharing one 10G transmit path among NUM_QUEUES AXI-Stream sources, e.g. generator replay and host DMA. It sits directly upstream of the per-port 10G tx queue, whose s_axis_tready it obeys. It never interleaves beats of different packets and can optionally enforce a programmable idle gap between packets. It also keeps per-queue sent-packet counters.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 64, data width of every stream.
- C_AXIS_TUSER_WIDTH, 128, tuser width, passed through untouched.
- NUM_QUEUES, 2, number of requesters; legal range 2..4.
- C_S_AXI_DATA_WIDTH, 32, width of configuration and counter words.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  NUM_QUEUES*C_AXIS_DATA_WIDTH  queue i occupies slice i.
- s_axis_tkeep  in  NUM_QUEUES*C_AXIS_DATA_WIDTH/8  per-queue keep.
- s_axis_tuser  in  NUM_QUEUES*C_AXIS_TUSER_WIDTH  per-queue user.
- s_axis_tvalid  in  NUM_QUEUES  per-queue valid.
- s_axis_tlast  in  NUM_QUEUES  per-queue last.
- s_axis_tready  out  NUM_QUEUES  per-queue ready.
- m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast  out  widths as above  merged stream.
- m_axis_tready  in  1  downstream ready.
- queue_enable  in  NUM_QUEUES  arbitration eligibility mask.
- ifg_cycles  in  C_S_AXI_DATA_WIDTH  idle cycles forced after each packet. Used only with the gap feature.
- clear  in  1  zeroes all counters.
- pkt_count  out  NUM_QUEUES*C_S_AXI_DATA_WIDTH  packets sent per queue.
- cur_grant  out  log2(NUM_QUEUES)  queue currently granted.
- busy  out  1  high in SEND or GAP.

## Operation
- The state machine has three states: IDLE, SEND and GAP.
- IDLE:
  - A queue is eligible when s_axis_tvalid[i] & queue_enable[i].
  - If any queue is eligible, the first eligible queue searched from rr_ptr+1 modulo NUM_QUEUES is registered into grant, and the state moves to SEND.
  - Otherwise the state stays in IDLE.
  - All outputs are 0 and s_axis_tready is 0.
- SEND:
  - m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid and m_axis_tlast equal the granted queue's slice combinationally.
  - s_axis_tready[grant] = m_axis_tready; all other ready bits are 0.
  - When m_axis_tvalid & m_axis_tready & m_axis_tlast:
    - rr_ptr <= grant.
    - pkt_count[grant] increments.
    - The state goes to GAP if the feature is compiled in and ifg_cycles != 0, else to IDLE.
- GAP: a down-counter is loaded with ifg_cycles at tlast and decrements each cycle. The state goes to IDLE when the count reaches 1. All outputs are 0.
- A source dropping tvalid mid-packet makes m_axis_tvalid go low and the state stays in SEND (no timeout).
- A queue_enable change in SEND or GAP takes effect only at the next IDLE decision; the packet in flight always completes.
- Counters are 32 bit and wrap modulo 2^32.
- clear takes priority over an increment in the same cycle.
- Reset:
  - state = IDLE, grant = 0, rr_ptr = NUM_QUEUES-1 (so queue 0 wins first), counters = 0, GAP counter = 0.
  - All outputs are 0: m_axis_*, s_axis_tready, pkt_count, cur_grant = 0, busy = 0.
  - A reset asserted mid-packet abandons that packet. The downstream sees a truncated packet, which is accepted.

## Timing
- Arbitration latency: an eligible tvalid sampled in IDLE at cycle t gives m_axis_tvalid at t+1.
- The minimum gap between packets is 1 cycle (the IDLE decision cycle), plus ifg_cycles when the gap feature is enabled.
- Within a packet the arbiter is zero-latency and passes one beat per cycle with no bubbles.
- A single-beat packet (tlast on the first beat) occupies exactly one SEND cycle.
- ifg_cycles is sampled at the tlast handshake; a later change does not alter a GAP already in progress.

## Configuration
- OSNT_TX_ARB_IFG_EN defined: the GAP state, the ifg_cycles counter and the ifg_cycles port are active.
- OSNT_TX_ARB_IFG_EN undefined: no GAP state; SEND goes to IDLE directly; ifg_cycles is ignored and no logic is generated for it.

## Structure
- Shared package osnt_tx_arb_pkg holds:
  - the state encoding constants (IDLE=0, SEND=1, GAP=2);
  - the log2 function;
  - the slice-index helper constants.
- Sub-module osnt_rr_pick: a combinational round-robin picker. Inputs are the eligible vector and the pointer; outputs are the winner index and an any-eligible flag. It is reusable by the rx side.

## Test plan
- Both queues continuously valid, 3-beat packets, ifg_cycles=0, m_axis_tready=1 -> output packet order q0,q1,q0,q1; each packet is separated by exactly 1 idle cycle; pkt_count = {2,2} after 4 packets.
- q1 asserts tvalid mid-way through a q0 packet -> no interleaving; q1's first beat appears 2 cycles after q0's tlast beat.
- m_axis_tready toggles 1,0,1,0 during a 5-beat packet -> every beat is delivered exactly once, and s_axis_tready of the non-granted queue stays 0 throughout.
- Macro defined, ifg_cycles=4 -> exactly 4 GAP cycles plus 1 IDLE cycle between consecutive packets; busy is high during GAP.
- queue_enable=2'b10 while q0 and q1 are both valid -> only q1 is served; q0's counter stays 0; q0 is served after enable returns to 2'b11.
- clear asserted on a tlast cycle, and reset asserted mid-packet -> the counter reads 0 after clear; after reset all outputs are 0 and the next grant is q0.

Source files
------------

// File: rtl/osnt_tx_arb_pkg.sv
// Shared constants and helpers for the OSNT tx packet arbiter and its round-robin picker.
package osnt_tx_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Bits per tkeep lane; tkeep width = data width / BYTE_W.
  localparam int BYTE_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/osnt_rr_pick.sv
// Combinational round-robin picker: first eligible index searched from ptr+1 modulo N.
module osnt_rr_pick
  import osnt_tx_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] win,
  output logic          any
);

  always_comb begin
    int d;
    int best;
    win  = '0;
    any  = 1'b0;
    best = N;
    d    = 0;
    // Rank each requester by its distance past ptr; the smallest distance wins.
    for (int j = 0; j < N; j++) begin
      d = (j + N - int'(ptr) - 1) % N;
      if (elig[PW'(j)] && d < best) begin
        best = d;
        win  = PW'(j);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/osnt_sume_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_QUEUES AXI-Stream sources onto one tx path.
// Define OSNT_TX_ARB_IFG_EN to add a programmable idle gap (ifg_cycles) after every packet.
module osnt_sume_tx_pkt_arbiter
  import osnt_tx_arb_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES         = 2,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  localparam int GW = clog2(NUM_QUEUES),
  localparam int KW = C_AXIS_DATA_WIDTH / BYTE_W
) (
  input  logic                                         axis_aclk,
  input  logic                                         axis_reset,
  input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [NUM_QUEUES*KW-1:0]                     s_axis_tkeep,
  input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                        s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                        s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                        s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic [KW-1:0]                                m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                m_axis_tuser,
  output logic                                         m_axis_tvalid,
  output logic                                         m_axis_tlast,
  input  logic                                         m_axis_tready,
  input  logic [NUM_QUEUES-1:0]                        queue_enable,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                ifg_cycles,
  input  logic                                         clear,
  output logic [NUM_QUEUES*C_S_AXI_DATA_WIDTH-1:0]     pkt_count,
  output logic [GW-1:0]                                cur_grant,
  output logic                                         busy
);

  logic [1:0]                    state;
  logic [GW-1:0]                 grant;
  logic [GW-1:0]                 rr_ptr;
  logic [GW-1:0]                 pick;
  logic                          any_elig;
  logic [NUM_QUEUES-1:0]         elig;
  logic                          last_beat;
  logic [C_S_AXI_DATA_WIDTH-1:0] cnt [NUM_QUEUES];

`ifdef OSNT_TX_ARB_IFG_EN
  logic [C_S_AXI_DATA_WIDTH-1:0] gap_cnt;
`else
  logic unused_ifg;
  assign unused_ifg = ^ifg_cycles;
`endif

  assign elig = s_axis_tvalid & queue_enable;

  osnt_rr_pick #(
    .N  (NUM_QUEUES),
    .PW (GW)
  ) u_pick (
    .elig (elig),
    .ptr  (rr_ptr),
    .win  (pick),
    .any  (any_elig)
  );

  // The granted slice is passed straight through so a packet moves one beat per cycle.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == ST_SEND) begin
      m_axis_tdata  = s_axis_tdata[int'(grant)*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
      m_axis_tkeep  = s_axis_tkeep[int'(grant)*KW +: KW];
      m_axis_tuser  = s_axis_tuser[int'(grant)*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
      m_axis_tvalid = s_axis_tvalid[grant];
      m_axis_tlast  = s_axis_tlast[grant];
      s_axis_tready[grant] = m_axis_tready;
    end
  end

  assign last_beat = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign busy      = (state != ST_IDLE);
  assign cur_grant = grant;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= GW'(NUM_QUEUES - 1);
`ifdef OSNT_TX_ARB_IFG_EN
      gap_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_elig) begin
            grant <= pick;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (last_beat) begin
            rr_ptr <= grant;
`ifdef OSNT_TX_ARB_IFG_EN
            if (ifg_cycles != '0) begin
              gap_cnt <= ifg_cycles;
              state   <= ST_GAP;
            end else begin
              state <= ST_IDLE;
            end
`else
            state <= ST_IDLE;
`endif
          end
        end
`ifdef OSNT_TX_ARB_IFG_EN
        ST_GAP: begin
          gap_cnt <= gap_cnt - C_S_AXI_DATA_WIDTH'(1);
          if (gap_cnt <= C_S_AXI_DATA_WIDTH'(1)) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // clear wins over a same-cycle increment.
  always_ff @(posedge axis_aclk) begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (axis_reset || clear) begin
        cnt[i] <= '0;
      end else if (last_beat && grant == GW'(i)) begin
        cnt[i] <= cnt[i] + C_S_AXI_DATA_WIDTH'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_cnt
    assign pkt_count[gi*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = cnt[gi];
  end

endmodule

// File: tb/tb_osnt_sume_tx_pkt_arbiter.sv
// Self-checking bench for osnt_sume_tx_pkt_arbiter: source models, per-queue scoreboard, vector table.
module tb_osnt_sume_tx_pkt_arbiter;

  localparam int NQ = 2;
  localparam int DW = 64;
  localparam int UW = 128;
  localparam int AW = 32;
  localparam int KW = DW / 8;
`ifdef OSNT_TX_ARB_IFG_EN
  localparam int EXP_GAP = 4;
`else
  localparam int EXP_GAP = 0;
`endif

  logic              axis_aclk = 1'b0;
  logic              axis_reset;
  logic [NQ*DW-1:0]  s_axis_tdata;
  logic [NQ*KW-1:0]  s_axis_tkeep;
  logic [NQ*UW-1:0]  s_axis_tuser;
  logic [NQ-1:0]     s_axis_tvalid;
  logic [NQ-1:0]     s_axis_tlast;
  logic [NQ-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [NQ-1:0]     queue_enable;
  logic [AW-1:0]     ifg_cycles;
  logic              clear;
  logic [NQ*AW-1:0]  pkt_count;
  logic              cur_grant;
  logic              busy;

  always #5 axis_aclk = ~axis_aclk;

  osnt_sume_tx_pkt_arbiter dut (
    .axis_aclk     (axis_aclk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .queue_enable  (queue_enable),
    .ifg_cycles    (ifg_cycles),
    .clear         (clear),
    .pkt_count     (pkt_count),
    .cur_grant     (cur_grant),
    .busy          (busy)
  );

  typedef struct {
    int            q;
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  typedef struct {
    logic [1:0] en;
    int         len0;
    int         len1;
    int         exp_n;
    int         o0;
    int         o1;
    int         c0;
    int         c1;
  } tv_t;

  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            pkt_seq = 0;
  beat_t         sb[$];
  int            starts[$];
  int            starts_q[$];
  int            lasts[$];
  bit            busy_log[$];
  logic [DW-1:0] src_dat [NQ][256];
  logic          src_lst [NQ][256];
  int            src_rd [NQ];
  int            src_wr [NQ];
  int            out_beats [NQ];
  bit            in_pkt = 1'b0;
  int            cur_q = 0;
  bit            tready_toggle = 1'b0;
  bit            clr_on_last = 1'b0;
  logic [NQ-1:0] hs;
  tv_t           tbl [9];

  function automatic logic [KW-1:0] keep_of(input logic [DW-1:0] d);
    return d[KW-1:0] ^ 8'h5A;
  endfunction

  function automatic logic [UW-1:0] user_of(input logic [DW-1:0] d);
    return {d, ~d};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_pkt(input int q, input int len);
    beat_t e;
    for (int b = 0; b < len; b++) begin
      e.q    = q;
      e.dat  = {8'(q), 24'(pkt_seq), 32'(b)};
      e.last = (b == len - 1);
      src_dat[q][src_wr[q] % 256] = e.dat;
      src_lst[q][src_wr[q] % 256] = e.last;
      src_wr[q]++;
      sb.push_back(e);
    end
    pkt_seq++;
  endtask

  task automatic drive();
    for (int q = 0; q < NQ; q++) begin
      if (src_rd[q] != src_wr[q]) begin
        s_axis_tvalid[q]          = 1'b1;
        s_axis_tdata[q*DW +: DW]  = src_dat[q][src_rd[q] % 256];
        s_axis_tkeep[q*KW +: KW]  = keep_of(src_dat[q][src_rd[q] % 256]);
        s_axis_tuser[q*UW +: UW]  = user_of(src_dat[q][src_rd[q] % 256]);
        s_axis_tlast[q]           = src_lst[q][src_rd[q] % 256];
      end else begin
        s_axis_tvalid[q] = 1'b0;
        s_axis_tlast[q]  = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    int            q;
    bit            found;
    logic [NQ-1:0] mask;
    hs = '0;
    busy_log.push_back(busy);
    if (axis_reset) return;
    mask = busy ? (NQ'(1) << cur_grant) : '0;
    chk("ready_only_granted", s_axis_tready & ~mask, 0);
    if (!busy) begin
      chk("idle_tvalid", m_axis_tvalid, 0);
      chk("idle_tdata", m_axis_tdata, 0);
      chk("idle_tready", s_axis_tready, 0);
    end
    for (int i = 0; i < NQ; i++) hs[i] = s_axis_tvalid[i] & s_axis_tready[i];
    if (m_axis_tvalid && m_axis_tready) begin
      q = int'(m_axis_tdata[DW-1:DW-8]);
      chk("beat_from_grant", q, cur_grant);
      if (q < NQ) chk("src_ready_on_beat", s_axis_tready[q], 1);
      if (in_pkt) begin
        chk("no_interleave", q, cur_q);
      end else begin
        starts.push_back(cyc);
        starts_q.push_back(q);
      end
      found = 1'b0;
      for (int i = 0; i < sb.size(); i++) begin
        if (!found && sb[i].q == q) begin
          found = 1'b1;
          chk("beat_data", m_axis_tdata, sb[i].dat);
          chk("beat_last", m_axis_tlast, sb[i].last);
          chk("beat_keep", m_axis_tkeep, keep_of(sb[i].dat));
          chk("beat_user", m_axis_tuser, user_of(sb[i].dat));
          sb.delete(i);
        end
      end
      if (!found) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_beat: got 0x%0h, expected no beat (cycle %0d)", m_axis_tdata, cyc);
      end
      if (q < NQ) out_beats[q]++;
      in_pkt = !m_axis_tlast;
      cur_q  = q;
      if (m_axis_tlast) begin
        lasts.push_back(cyc);
        if (clr_on_last) clear = 1'b1;
      end
    end
  endtask

  task automatic step();
    drive();
    if (tready_toggle) m_axis_tready = ~m_axis_tready;
    @(negedge axis_aclk);
    monitor();
    @(posedge axis_aclk);
    #1;
    for (int q = 0; q < NQ; q++) if (hs[q]) src_rd[q]++;
    clear = 1'b0;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    starts.delete();
    starts_q.delete();
    lasts.delete();
    out_beats = '{default: 0};
  endtask

  task automatic do_reset();
    axis_reset = 1'b1;
    step();
    step();
    axis_reset = 1'b0;
    for (int q = 0; q < NQ; q++) src_rd[q] = src_wr[q];
    sb.delete();
    in_pkt = 1'b0;
    drive();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_m_tdata"}, m_axis_tdata, 0);
    chk({tag, "_m_tkeep"}, m_axis_tkeep, 0);
    chk({tag, "_m_tuser"}, m_axis_tuser, 0);
    chk({tag, "_m_tlast"}, m_axis_tlast, 0);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
    chk({tag, "_pkt_count"}, pkt_count, 0);
    chk({tag, "_cur_grant"}, cur_grant, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int guard;
    int nb;
    int load_at;

    // {enable, len0, len1, exp packets, 1st queue, 2nd queue, cumulative count q0, q1}
    tbl[0] = '{2'b11, 3, 3, 2, 0, 1, 1, 1};
    tbl[1] = '{2'b11, 1, 2, 2, 0, 1, 2, 2};
    tbl[2] = '{2'b10, 2, 1, 1, 1, 0, 2, 3};
    tbl[3] = '{2'b11, 0, 4, 2, 0, 1, 3, 4};
    tbl[4] = '{2'b11, 0, 2, 1, 1, 0, 3, 5};
    tbl[5] = '{2'b11, 5, 0, 1, 0, 0, 4, 5};
    tbl[6] = '{2'b11, 2, 2, 2, 1, 0, 5, 6};
    tbl[7] = '{2'b01, 0, 3, 0, 0, 0, 5, 6};
    tbl[8] = '{2'b11, 1, 0, 2, 1, 0, 6, 7};

    axis_reset    = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    queue_enable  = 2'b11;
    ifg_cycles    = '0;
    clear         = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      src_rd[q] = 0;
      src_wr[q] = 0;
    end
    #1;
    do_reset();
    check_idle_outputs("reset");

    for (int i = 0; i < 9; i++) begin
      queue_enable = tbl[i].en;
      clear_logs();
      if (tbl[i].len0 > 0) load_pkt(0, tbl[i].len0);
      if (tbl[i].len1 > 0) load_pkt(1, tbl[i].len1);
      run(40);
      chk($sformatf("tv%0d_npkts", i), starts_q.size(), tbl[i].exp_n);
      if (starts_q.size() > 0 && tbl[i].exp_n > 0) chk($sformatf("tv%0d_first", i), starts_q[0], tbl[i].o0);
      if (starts_q.size() > 1 && tbl[i].exp_n > 1) chk($sformatf("tv%0d_second", i), starts_q[1], tbl[i].o1);
      chk($sformatf("tv%0d_cnt0", i), pkt_count[AW-1:0], tbl[i].c0);
      chk($sformatf("tv%0d_cnt1", i), pkt_count[2*AW-1:AW], tbl[i].c1);
    end
    chk("table_sb_drained", sb.size(), 0);

    // Both queues backlogged with 3-beat packets after reset.
    queue_enable = 2'b11;
    do_reset();
    clear_logs();
    load_pkt(0, 3); load_pkt(0, 3);
    load_pkt(1, 3); load_pkt(1, 3);
    run(40);
    chk("rr_npkts", starts_q.size(), 4);
    for (int k = 0; k < 4 && k < starts_q.size() && k < lasts.size(); k++) begin
      chk($sformatf("rr_order%0d", k), starts_q[k], k % 2);
      chk($sformatf("rr_no_bubble%0d", k), lasts[k] - starts[k], 2);
      if (k < 3 && k + 1 < starts.size()) chk($sformatf("rr_gap%0d", k), starts[k+1] - lasts[k], 2);
    end
    chk("rr_cnt0", pkt_count[AW-1:0], 2);
    chk("rr_cnt1", pkt_count[2*AW-1:AW], 2);

    // q1 arrives while q0 is mid-packet.
    clear_logs();
    load_at = cyc;
    load_pkt(0, 4);
    run(2);
    load_pkt(1, 2);
    run(30);
    chk("mid_npkts", starts_q.size(), 2);
    if (starts.size() >= 2 && lasts.size() >= 1) begin
      chk("mid_latency", starts[0] - load_at, 1);
      chk("mid_order0", starts_q[0], 0);
      chk("mid_order1", starts_q[1], 1);
      chk("mid_q1_after_last", starts[1] - lasts[0], 2);
    end

    // Downstream ready toggling during a 5-beat packet.
    clear_logs();
    m_axis_tready  = 1'b0;
    tready_toggle  = 1'b1;
    load_pkt(0, 5);
    load_pkt(1, 2);
    run(30);
    tready_toggle  = 1'b0;
    m_axis_tready  = 1'b1;
    chk("bp_beats_q0", out_beats[0], 5);
    chk("bp_beats_q1", out_beats[1], 2);
    chk("bp_order0", (starts_q.size() > 0) ? starts_q[0] : -1, 0);
    chk("bp_sb_drained", sb.size(), 0);

    // Inter-packet gap; ifg_cycles changed after the first tlast must not affect that gap.
    clear_logs();
    ifg_cycles = 4;
    load_pkt(0, 2);
    load_pkt(0, 2);
    guard = 0;
    while (lasts.size() < 1 && guard < 20) begin
      step();
      guard++;
    end
    chk("ifg_first_tlast_seen", lasts.size() >= 1, 1);
    ifg_cycles = 1;
    run(30);
    ifg_cycles = 0;
    chk("ifg_npkts", starts.size(), 2);
    if (starts.size() >= 2 && lasts.size() >= 1) begin
      chk("ifg_spacing", starts[1] - lasts[0], EXP_GAP + 2);
      nb = 0;
      for (int c = lasts[0] + 1; c < starts[1]; c++) nb += int'(busy_log[c]);
      chk("ifg_busy_cycles", nb, EXP_GAP);
    end

    // clear asserted in the same cycle as a tlast handshake.
    clear_logs();
    clr_on_last = 1'b1;
    load_pkt(0, 1);
    run(10);
    clr_on_last = 1'b0;
    chk("clear_on_last_cnt0", pkt_count[AW-1:0], 0);
    chk("clear_on_last_cnt1", pkt_count[2*AW-1:AW], 0);
    load_pkt(0, 1);
    run(10);
    chk("count_after_clear", pkt_count[AW-1:0], 1);

    // Reset in the middle of a q0 packet.
    clear_logs();
    load_pkt(0, 5);
    guard = 0;
    while (out_beats[0] < 2 && guard < 20) begin
      step();
      guard++;
    end
    chk("rst_mid_pkt_started", out_beats[0] >= 2, 1);
    do_reset();
    check_idle_outputs("rst_mid");
    clear_logs();
    load_pkt(1, 2);
    load_pkt(0, 2);
    run(30);
    chk("rst_npkts", starts_q.size(), 2);
    chk("rst_first_grant", (starts_q.size() > 0) ? starts_q[0] : -1, 0);

    chk("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
